// File: rtl/ace_snoop_responder.sv
// ace_snoop_responder: cache-side end of the ACE snoop channel.
// Takes one AC snoop at a time, looks the line up in the dcache, returns the
// CR response, streams the frozen line on CD when data transfer is required,
// then issues the resulting coherency update (invalidate / clean / shared).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | ready for a snoop; ac_ready_o high
// S_LOOKUP | cache lookup request held until granted
// S_WAIT   | waiting for the lookup result; decode response on arrival
// S_RESP   | CR response presented until handshaken
// S_DATA   | CD beats, wrapping from the start word
// S_UPDATE | cache state update presented until accepted
module ace_snoop_responder #(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int LineWidth = 128
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 ac_valid_i,
    output logic                 ac_ready_o,
    input  logic [AddrWidth-1:0] ac_addr_i,
    input  logic [3:0]           ac_snoop_i,
    input  logic [2:0]           ac_prot_i,

    output logic                 cr_valid_o,
    input  logic                 cr_ready_i,
    output logic [4:0]           cr_resp_o,

    output logic                 cd_valid_o,
    input  logic                 cd_ready_i,
    output logic [DataWidth-1:0] cd_data_o,
    output logic                 cd_last_o,

    output logic                 lookup_req_o,
    input  logic                 lookup_gnt_i,
    output logic [AddrWidth-1:0] lookup_addr_o,
    input  logic                 lookup_valid_i,
    input  logic                 lookup_hit_i,
    input  logic                 lookup_dirty_i,
    input  logic                 lookup_shared_i,
    input  logic [LineWidth-1:0] lookup_data_i,

    output logic                 upd_valid_o,
    input  logic                 upd_ready_i,
    output logic [AddrWidth-1:0] upd_addr_o,
    output logic                 upd_invalidate_o,
    output logic                 upd_clean_o,
    output logic                 upd_shared_o,

    output logic                 busy_o
);

    localparam int NumBeats = LineWidth / DataWidth;
    localparam int LineOffW = $clog2(LineWidth / 8);
    localparam int WordOffW = $clog2(DataWidth / 8);
    localparam int BeatW    = (NumBeats > 1) ? $clog2(NumBeats) : 1;

    localparam logic [AddrWidth-1:0] LineMask = ~(AddrWidth'((LineWidth / 8) - 1));
    localparam logic [BeatW-1:0]     LastCnt  = BeatW'(NumBeats - 1);

    // Supported ACE snoop encodings
    localparam logic [3:0] SnReadOnce     = 4'b0000;
    localparam logic [3:0] SnReadShared   = 4'b0001;
    localparam logic [3:0] SnReadClean    = 4'b0010;
    localparam logic [3:0] SnReadNsd      = 4'b0011;
    localparam logic [3:0] SnReadUnique   = 4'b0111;
    localparam logic [3:0] SnCleanShared  = 4'b1000;
    localparam logic [3:0] SnCleanInvalid = 4'b1001;
    localparam logic [3:0] SnMakeInvalid  = 4'b1101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WAIT,
        S_RESP,
        S_DATA,
        S_UPDATE
    } state_e;

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [3:0]             snoop_q, snoop_d;
    logic [BeatW-1:0]       start_q, start_d;
    logic [BeatW-1:0]       beat_q, beat_d;
    logic [BeatW-1:0]       cnt_q, cnt_d;
    logic [4:0]             resp_q, resp_d;
    logic                   inv_q, inv_d;
    logic                   clean_q, clean_d;
    logic                   shared_q, shared_d;
    logic [LineWidth-1:0]   data_q, data_d;

    logic [BeatW-1:0]       ac_start_word;
    logic [4:0]             dec_resp;
    logic                   dec_inv, dec_clean, dec_shared;
    logic                   need_upd;
    logic                   unused_ok;

    assign unused_ok = ^ac_prot_i;

    // Start word is the beat index within the line addressed by the snoop
    if (NumBeats > 1) begin : g_start_word
        assign ac_start_word = ac_addr_i[LineOffW-1:WordOffW];
    end else begin : g_single_beat
        assign ac_start_word = '0;
    end

    // Decode response and required cache action from the lookup result
    always_comb begin
        logic wu;
        wu         = lookup_hit_i && !lookup_shared_i;
        dec_resp   = 5'b00000;
        dec_inv    = 1'b0;
        dec_clean  = 1'b0;
        dec_shared = 1'b0;
        unique case (snoop_q)
            SnReadOnce: begin
                dec_resp = {wu, 1'b1, 1'b0, 1'b0, 1'b1};
            end
            SnReadShared, SnReadClean, SnReadNsd: begin
                dec_resp   = {wu, 1'b1, lookup_dirty_i, 1'b0, 1'b1};
                dec_clean  = lookup_dirty_i;
                dec_shared = 1'b1;
            end
            SnReadUnique: begin
                dec_resp = {wu, 1'b0, lookup_dirty_i, 1'b0, 1'b1};
                dec_inv  = 1'b1;
            end
            SnCleanShared: begin
                dec_resp  = {wu, 1'b1, lookup_dirty_i, 1'b0, lookup_dirty_i};
                dec_clean = lookup_dirty_i;
            end
            SnCleanInvalid: begin
                dec_resp = {wu, 1'b0, lookup_dirty_i, 1'b0, lookup_dirty_i};
                dec_inv  = 1'b1;
            end
            SnMakeInvalid: begin
                dec_resp = {wu, 1'b0, 1'b0, 1'b0, 1'b0};
                dec_inv  = 1'b1;
            end
            default: begin
                dec_resp = 5'b00010;
            end
        endcase
        // A miss on a supported type answers with an all-zero response
        if (!lookup_hit_i && dec_resp != 5'b00010) begin
            dec_resp   = 5'b00000;
            dec_inv    = 1'b0;
            dec_clean  = 1'b0;
            dec_shared = 1'b0;
        end
    end

    assign need_upd = inv_q || clean_q || shared_q;

    // State register and transaction context
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            snoop_q  <= '0;
            start_q  <= '0;
            beat_q   <= '0;
            cnt_q    <= '0;
            resp_q   <= '0;
            inv_q    <= 1'b0;
            clean_q  <= 1'b0;
            shared_q <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            snoop_q  <= snoop_d;
            start_q  <= start_d;
            beat_q   <= beat_d;
            cnt_q    <= cnt_d;
            resp_q   <= resp_d;
            inv_q    <= inv_d;
            clean_q  <= clean_d;
            shared_q <= shared_d;
            data_q   <= data_d;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        snoop_d      = snoop_q;
        start_d      = start_q;
        beat_d       = beat_q;
        cnt_d        = cnt_q;
        resp_d       = resp_q;
        inv_d        = inv_q;
        clean_d      = clean_q;
        shared_d     = shared_q;
        data_d       = data_q;
        ac_ready_o   = 1'b0;
        lookup_req_o = 1'b0;
        cr_valid_o   = 1'b0;
        cd_valid_o   = 1'b0;
        cd_last_o    = 1'b0;
        upd_valid_o  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                ac_ready_o = !rst_i;
                if (ac_valid_i) begin
                    addr_d  = ac_addr_i;
                    snoop_d = ac_snoop_i;
                    start_d = ac_start_word;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                lookup_req_o = 1'b1;
                if (lookup_gnt_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lookup_valid_i) begin
                    resp_d   = dec_resp;
                    inv_d    = dec_inv;
                    clean_d  = dec_clean;
                    shared_d = dec_shared;
                    data_d   = lookup_data_i;
                    beat_d   = start_q;
                    cnt_d    = '0;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                cr_valid_o = 1'b1;
                if (cr_ready_i) begin
                    if (resp_q[0]) begin
                        state_d = S_DATA;
                    end else if (need_upd) begin
                        state_d = S_UPDATE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                cd_valid_o = 1'b1;
                cd_last_o  = (cnt_q == LastCnt);
                if (cd_ready_i) begin
                    // Index width equals log2(NumBeats), so +1 wraps on its own
                    beat_d = (NumBeats > 1) ? beat_q + 1'b1 : '0;
                    cnt_d  = (NumBeats > 1) ? cnt_q + 1'b1 : '0;
                    if (cnt_q == LastCnt) begin
                        state_d = need_upd ? S_UPDATE : S_IDLE;
                    end
                end
            end
            S_UPDATE: begin
                upd_valid_o = 1'b1;
                if (upd_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cr_resp_o        = resp_q;
    assign cd_data_o        = data_q[beat_q * DataWidth +: DataWidth];
    assign lookup_addr_o    = addr_q & LineMask;
    assign upd_addr_o       = addr_q & LineMask;
    assign upd_invalidate_o = inv_q;
    assign upd_clean_o      = clean_q;
    assign upd_shared_o     = shared_q;
    assign busy_o           = (state_q != S_IDLE);

endmodule

// File: doc/ace_snoop_responder.md
Name: ace_snoop_responder

Overview:
- Master-side (cache-side) end of the ACE snoop channel: accepts AC snoop requests from the coherency interconnect, looks the line up in the local dcache, and returns the CR response plus CD line data when required.
- Applies the resulting coherency state change (invalidate / clean / mark-shared) to the cache.
- Sits between a core's dcache and the interconnect's per-port snoop request/response bus.
- Serves one snoop at a time.

Parameters:
- AddrWidth, 64, AC address width.
- DataWidth, 64, CD data width; power of two, at most LineWidth.
- LineWidth, 128, dcache line width in bits; LineWidth/DataWidth = NumBeats (power of two, ≥1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- ac_valid_i  in  1  snoop address valid.
- ac_ready_o  out  1  snoop address ready.
- ac_addr_i  in  AddrWidth  snoop address.
- ac_snoop_i  in  4  ACE snoop type.
- ac_prot_i  in  3  ignored.
- cr_valid_o  out  1  snoop response valid.
- cr_ready_i  in  1  snoop response ready.
- cr_resp_o  out  5  {WasUnique, IsShared, PassDirty, Error, DataTransfer}, bit 4..0.
- cd_valid_o  out  1  snoop data valid.
- cd_ready_i  in  1  snoop data ready.
- cd_data_o  out  DataWidth  snoop data beat.
- cd_last_o  out  1  last beat.
- lookup_req_o  out  1  cache lookup request.
- lookup_gnt_i  in  1  lookup granted.
- lookup_addr_o  out  AddrWidth  line-aligned lookup address.
- lookup_valid_i  in  1  lookup result valid; arrives ≥1 cycle after grant.
- lookup_hit_i, lookup_dirty_i, lookup_shared_i  in  1 each  line state.
- lookup_data_i  in  LineWidth  line data.
- upd_valid_o  out  1  state update request.
- upd_ready_i  in  1  update accepted.
- upd_addr_o  out  AddrWidth  line-aligned update address.
- upd_invalidate_o, upd_clean_o, upd_shared_o  out  1 each  update actions.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst_i sampled high at a clock edge):
  - FSM → IDLE; beat counter 0.
  - All valid/req outputs 0; ac_ready_o 0 during reset, 1 in IDLE afterwards.
  - Data/addr registers 0.
  - Reset mid-transaction aborts it silently: no CR/CD, no update.
- FSM: IDLE → LOOKUP → WAIT → RESP → [DATA] → [UPDATE] → IDLE.
- IDLE: ac_ready_o=1. On ac_valid_i: register addr, snoop, and start word = addr[$clog2(LineWidth/8)-1:$clog2(DataWidth/8)]; go to LOOKUP.
- LOOKUP: lookup_req_o=1 with line-aligned addr, held until lookup_gnt_i; then WAIT.
- WAIT: on lookup_valid_i, register hit/dirty/shared/data and compute resp; go to RESP.
- RESP: cr_valid_o=1, cr_resp_o stable until cr_ready_i. Then:
  - DATA if DataTransfer=1;
  - else UPDATE if an action is needed;
  - else IDLE.
- DATA:
  - NumBeats beats, starting at the start word, index incrementing modulo NumBeats (wrap-around).
  - cd_last_o on beat NumBeats-1; beat advances only on cd_valid_o&&cd_ready_i.
  - After the last beat: UPDATE if an action is needed, else IDLE.
- UPDATE: upd_valid_o=1 with action bits held until upd_ready_i; then IDLE.
- ac_ready_o=0 outside IDLE; back-to-back snoops therefore take ≥4 cycles each.
- Response rules. Let h=hit, d=dirty, s=shared, WU=h&!s.
  - Miss (any type): resp=0, no CD, no update.
  - ReadOnce 0000: DT=1, IsShared=1, WU; PassDirty=0; no update.
  - ReadShared 0001, ReadClean 0010, ReadNotSharedDirty 0011: DT=1, IsShared=1, PassDirty=d, WU; update clean=d, shared=1.
  - ReadUnique 0111: DT=1, PassDirty=d, IsShared=0, WU; update invalidate=1.
  - CleanShared 1000: DT=d, PassDirty=d, IsShared=1, WU; update clean=1 only if d.
  - CleanInvalid 1001: DT=d, PassDirty=d, IsShared=0, WU; update invalidate=1.
  - MakeInvalid 1101: DT=0, IsShared=0, WU; update invalidate=1.
  - Any other encoding: resp Error=1, other bits 0, no CD, no update.
- Error=0 for every supported type.
- CR is always fully handshaken before the first CD beat.
- Line data is frozen in the register, so the cache may change after WAIT without affecting CD.
- ac_valid_i asserted during reset: not accepted until the first IDLE cycle after reset release.

Test Plan:
- ReadShared 0x1040, hit dirty unique, data 0xBBBB_AAAA (words A,B) → cr_resp=5'b11101; CD beats A then B, last on B; update clean=1, shared=1.
- ReadUnique 0x1048, hit clean shared → cr_resp=5'b00001; CD starts at word 1 then wraps to word 0; update invalidate=1.
- CleanShared, hit clean → cr_resp=5'b01000; no CD, no update. Same with dirty → 5'b01101, 2 beats, update clean=1.
- Any type, miss → cr_resp=0, no CD, no upd_valid_o; busy_o drops the cycle after the CR handshake.
- Snoop 0101 → cr_resp=5'b00010, no CD or update. Backpressure case: cr_ready_i low 5 cycles, cd_ready_i toggling → resp and data held stable throughout, exact beat count.
- rst_i asserted during the DATA beat 0 handshake → next cycle all valids 0. After release, a new snoop completes correctly with beat count restarting at the start word.
